// File: rtl/iob_eth_mii_rx.sv
// MII receive framer: strips preamble/SFD, assembles bytes, filters on destination MAC and
// writes the frame into the RX byte buffer. Define ETH_RX_CRC_EN to enable the FCS check.
module iob_eth_mii_rx #(
    parameter logic [47:0] MAC_ADDR   = 48'h0123456789AB,
    parameter int unsigned BUF_ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_dv,
    input  logic [3:0]            rx_data,
    input  logic                  rcv_ack,
    output logic                  buf_we,
    output logic [BUF_ADDR_W-1:0] buf_addr,
    output logic [7:0]            buf_wdata,
    output logic                  rx_ready,
    output logic [BUF_ADDR_W-1:0] rx_nbytes,
    output logic                  crc_err,
    output logic                  frame_drop
);

    typedef enum logic [2:0] {StIdle, StPreamble, StData, StDrop, StDone} state_e;

    localparam logic [BUF_ADDR_W-1:0] HdrBytes = BUF_ADDR_W'(6);
    localparam logic [BUF_ADDR_W-1:0] MinBytes = BUF_ADDR_W'(14);
    localparam logic [BUF_ADDR_W-1:0] CountMax = '1;

    state_e                r_state;
    logic                  r_odd;
    logic [3:0]            r_low;
    logic [BUF_ADDR_W-1:0] r_count;
    logic                  r_mac_ok;
    logic                  r_bc_ok;

    logic [7:0] w_byte;
    logic [7:0] w_mac_byte;
    logic       w_mac_hit;
    logic       w_bc_hit;
    logic       w_filter_fail;

    assign w_byte = {rx_data, r_low};

    always_comb begin
        case (r_count[2:0])
            3'd0:    w_mac_byte = MAC_ADDR[47:40];
            3'd1:    w_mac_byte = MAC_ADDR[39:32];
            3'd2:    w_mac_byte = MAC_ADDR[31:24];
            3'd3:    w_mac_byte = MAC_ADDR[23:16];
            3'd4:    w_mac_byte = MAC_ADDR[15:8];
            3'd5:    w_mac_byte = MAC_ADDR[7:0];
            default: w_mac_byte = 8'h00;
        endcase
    end

    assign w_mac_hit     = r_mac_ok && (w_byte == w_mac_byte);
    assign w_bc_hit      = r_bc_ok && (w_byte == 8'hFF);
    assign w_filter_fail = (r_count < HdrBytes) && !w_mac_hit && !w_bc_hit;

`ifdef ETH_RX_CRC_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [31:0] w_residue;

    // Reflected CRC-32; the residue is compared in MSB-first bit order.
    always_comb begin
        w_crc_next = r_crc ^ {24'h0, w_byte};
        for (int i = 0; i < 8; i++) begin
            w_crc_next = w_crc_next[0] ? ((w_crc_next >> 1) ^ 32'hEDB88320) : (w_crc_next >> 1);
        end
        for (int i = 0; i < 32; i++) begin
            w_residue[i] = r_crc[31-i];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_odd      <= 1'b0;
            r_low      <= 4'h0;
            r_count    <= '0;
            r_mac_ok   <= 1'b1;
            r_bc_ok    <= 1'b1;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= 8'h00;
            rx_ready   <= 1'b0;
            rx_nbytes  <= '0;
            crc_err    <= 1'b0;
            frame_drop <= 1'b0;
`ifdef ETH_RX_CRC_EN
            r_crc      <= '1;
`endif
        end else begin
            buf_we     <= 1'b0;
            frame_drop <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_count  <= '0;
                    r_odd    <= 1'b0;
                    r_mac_ok <= 1'b1;
                    r_bc_ok  <= 1'b1;
`ifdef ETH_RX_CRC_EN
                    r_crc    <= '1;
`endif
                    if (rx_dv) begin
                        if (rx_data == 4'h5) begin
                            r_state <= StPreamble;
                        end else begin
                            r_state    <= StDrop;
                            frame_drop <= 1'b1;
                        end
                    end
                end
                StPreamble: begin
                    if (rx_dv && rx_data == 4'hD) begin
                        r_state <= StData;
                    end else if (!rx_dv || rx_data != 4'h5) begin
                        r_state    <= StDrop;
                        frame_drop <= 1'b1;
                    end
                end
                StData: begin
                    if (!rx_dv) begin
                        if (r_odd || r_count < MinBytes) begin
                            r_state    <= StDrop;
                            frame_drop <= 1'b1;
                        end else begin
                            r_state   <= StDone;
                            rx_ready  <= 1'b1;
                            rx_nbytes <= r_count;
`ifdef ETH_RX_CRC_EN
                            crc_err   <= (w_residue != 32'hC704DD7B);
`else
                            crc_err   <= 1'b0;
`endif
                        end
                    end else if (!r_odd) begin
                        r_low <= rx_data;
                        r_odd <= 1'b1;
                    end else begin
                        r_odd <= 1'b0;
                        // The offending byte is never written; the counter saturates.
                        if (w_filter_fail || r_count == CountMax) begin
                            r_state    <= StDrop;
                            frame_drop <= 1'b1;
                        end else begin
                            buf_we    <= 1'b1;
                            buf_addr  <= r_count;
                            buf_wdata <= w_byte;
                            r_count   <= r_count + 1'b1;
                            if (r_count < HdrBytes) begin
                                r_mac_ok <= w_mac_hit;
                                r_bc_ok  <= w_bc_hit;
                            end
`ifdef ETH_RX_CRC_EN
                            r_crc     <= w_crc_next;
`endif
                        end
                    end
                end
                StDrop: begin
                    if (!rx_dv) begin
                        r_state <= StIdle;
                    end
                end
                StDone: begin
                    // A frame already in flight at release time is discarded silently.
                    if (rcv_ack) begin
                        rx_ready <= 1'b0;
                        r_state  <= rx_dv ? StDrop : StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_mii_rx.sv
// Scoreboard bench for iob_eth_mii_rx: a frame-level model predicts buffer writes and
// frame outcomes; a monitor compares them against the DUT as they appear.
module tb_iob_eth_mii_rx;

    localparam logic [47:0] MacAddr = 48'h0123456789AB;
    localparam int          MaxBytes = 2047;
`ifdef ETH_RX_CRC_EN
    localparam bit CrcEn = 1'b1;
`else
    localparam bit CrcEn = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed { logic [10:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic is_done; logic [10:0] nbytes; logic crc; } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [3:0]  rx_data;
    logic        rcv_ack;
    logic        buf_we;
    logic [10:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic        rx_ready;
    logic [10:0] rx_nbytes;
    logic        crc_err;
    logic        frame_drop;

    int      n_checks = 0;
    int      n_fail = 0;
    bit      mon_en = 1'b0;
    bit      rdy_prev = 1'b0;
    bit      exp_done;
    wr_t     wq[$];
    ev_t     eq[$];
    byte_q_t frm;

    iob_eth_mii_rx #(
        .MAC_ADDR  (MacAddr),
        .BUF_ADDR_W(11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_dv     (rx_dv),
        .rx_data   (rx_data),
        .rcv_ack   (rcv_ack),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .rx_ready  (rx_ready),
        .rx_nbytes (rx_nbytes),
        .crc_err   (crc_err),
        .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (buf_we) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             buf_addr, buf_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", {21'h0, buf_addr}, {21'h0, w.addr});
                    chk("write_data", {24'h0, buf_wdata}, {24'h0, w.data});
                end
            end
            if (frame_drop || (rx_ready && !rdy_prev)) begin
                if (eq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got drop=%0b ready=%0b expected none",
                             frame_drop, rx_ready);
                end else begin
                    ev_t e;
                    e = eq.pop_front();
                    chk("event_is_done", {31'h0, rx_ready && !frame_drop}, {31'h0, e.is_done});
                    if (e.is_done) begin
                        chk("rx_nbytes", {21'h0, rx_nbytes}, {21'h0, e.nbytes});
                        chk("crc_err", {31'h0, crc_err}, {31'h0, e.crc});
                    end
                end
            end
            rdy_prev = rx_ready;
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_we"}, {31'h0, buf_we}, 0);
        chk({name, "_addr"}, {21'h0, buf_addr}, 0);
        chk({name, "_wdata"}, {24'h0, buf_wdata}, 0);
        chk({name, "_ready"}, {31'h0, rx_ready}, 0);
        chk({name, "_nbytes"}, {21'h0, rx_nbytes}, 0);
        chk({name, "_crc"}, {31'h0, crc_err}, 0);
        chk({name, "_drop"}, {31'h0, frame_drop}, 0);
    endtask

    task automatic append_fcs();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            c ^= {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(8'(c >> (8 * i)));
    endtask

    // kind: 0 local MAC, 1 broadcast, 2 02:00:00:00:00:01, 3 random destination
    task automatic build_frame(input int kind, input int plen, input bit fcs);
        logic [47:0] m = MacAddr;
        frm.delete();
        for (int i = 0; i < 6; i++) begin
            case (kind)
                0: frm.push_back(m[47-8*i -: 8]);
                1: frm.push_back(8'hFF);
                2: frm.push_back((i == 0) ? 8'h02 : (i == 5) ? 8'h01 : 8'h00);
                default: frm.push_back(8'($urandom));
            endcase
        end
        for (int i = 0; i < 6; i++) frm.push_back(m[47-8*i -: 8]);
        for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
        if (fcs) append_fcs();
    endtask

    task automatic expect_frame(input bit pre_ok, input bit extra, input bit bad);
        logic [47:0] m = MacAddr;
        bit mac_ok = 1'b1;
        bit bc_ok = 1'b1;
        exp_done = 1'b0;
        if (!pre_ok) begin
            eq.push_back('{is_done: 1'b0, nbytes: 11'd0, crc: 1'b0});
            return;
        end
        for (int i = 0; i < frm.size(); i++) begin
            if (i < 6) begin
                mac_ok &= (frm[i] == m[47-8*i -: 8]);
                bc_ok &= (frm[i] == 8'hFF);
            end
            if (!mac_ok && !bc_ok || i == MaxBytes) begin
                eq.push_back('{is_done: 1'b0, nbytes: 11'd0, crc: 1'b0});
                return;
            end
            wq.push_back('{addr: 11'(i), data: frm[i]});
        end
        if (extra || frm.size() < 14) begin
            eq.push_back('{is_done: 1'b0, nbytes: 11'd0, crc: 1'b0});
        end else begin
            eq.push_back('{is_done: 1'b1, nbytes: 11'(frm.size()), crc: CrcEn && bad});
            exp_done = 1'b1;
        end
    endtask

    task automatic send_frame(input int pre_len, input int bad_pre, input bit extra,
                              input int ack_at);
        logic [3:0] nib[$];
        int k = 0;
        for (int i = 0; i < pre_len; i++) begin
            if (i == bad_pre) begin
                logic [3:0] v;
                do v = 4'($urandom); while (v == 4'h5 || v == 4'hD);
                nib.push_back(v);
            end else begin
                nib.push_back(4'h5);
            end
        end
        nib.push_back(4'hD);
        foreach (frm[i]) begin
            nib.push_back(frm[i][3:0]);
            nib.push_back(frm[i][7:4]);
        end
        if (extra) nib.push_back(4'($urandom));
        foreach (nib[i]) begin
            @(posedge clk); #1;
            rx_dv = 1'b1;
            rx_data = nib[i];
            rcv_ack = (k == ack_at);
            k++;
        end
        @(posedge clk); #1;
        rx_dv = 1'b0;
        rx_data = 4'h0;
        rcv_ack = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: rx_ready got 0 expected 1 within 200 cycles", name);
        end
    endtask

    task automatic ack();
        @(posedge clk); #1;
        rcv_ack = 1'b1;
        @(posedge clk); #1;
        rcv_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_ready", {31'h0, rx_ready}, 0);
    endtask

    initial begin
        logic [7:0] hello[9] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h50, 8'h43, 8'h21};
        int a_len;
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rx_data = 4'h0;
        rcv_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Loopback frame, 27 bytes.
        build_frame(0, 0, 1'b0);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        foreach (hello[i]) frm.push_back(hello[i]);
        append_fcs();
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);
        wait_ready("loopback");
        ack();

        // Foreign destination, then 60-byte broadcast.
        build_frame(2, 11, 1'b1);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);
        build_frame(1, 44, 1'b1);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);
        wait_ready("broadcast60");
        ack();

        // Runt (13 bytes), odd nibble count, then a normal frame.
        build_frame(0, 1, 1'b0);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);
        build_frame(0, 8, 1'b0);
        expect_frame(1'b1, 1'b1, 1'b0);
        send_frame(15, -1, 1'b1, -1);
        build_frame(0, 20, 1'b1);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(7, -1, 1'b0, -1);
        wait_ready("after_runt");
        ack();

        // Frames arriving while DONE are ignored; release mid-frame drops silently.
        build_frame(1, 30, 1'b1);
        expect_frame(1'b1, 1'b0, 1'b0);
        a_len = frm.size();
        send_frame(15, -1, 1'b0, -1);
        wait_ready("done_hold");
        build_frame(0, 40, 1'b1);
        send_frame(15, -1, 1'b0, -1);
        chk("done_hold_nbytes", {21'h0, rx_nbytes}, 32'(a_len));
        chk("done_hold_ready", {31'h0, rx_ready}, 1);
        build_frame(0, 40, 1'b1);
        send_frame(15, -1, 1'b0, 40);
        chk("ack_in_frame_ready", {31'h0, rx_ready}, 0);
        build_frame(0, 25, 1'b1);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);
        wait_ready("third_frame");
        ack();

        // Payload bit flip after the FCS was computed.
        build_frame(0, 30, 1'b1);
        frm[20] = frm[20] ^ 8'h10;
        expect_frame(1'b1, 1'b0, 1'b1);
        send_frame(15, -1, 1'b0, -1);
        wait_ready("bitflip");
        ack();

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            int bad_pre = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            bit extra = ($urandom_range(0, 7) == 0);
            bit bad = 1'b0;
            build_frame($urandom_range(0, 3), $urandom_range(0, 60), 1'b1);
            if (frm.size() >= 17 && $urandom_range(0, 3) == 0) begin
                int idx = $urandom_range(12, frm.size() - 5);
                frm[idx] = frm[idx] ^ (8'h1 << $urandom_range(0, 7));
                bad = 1'b1;
            end
            expect_frame(bad_pre < 0, extra, bad);
            send_frame($urandom_range(4, 15), bad_pre, extra, -1);
            if (exp_done) begin
                wait_ready("random");
                ack();
            end
        end

        // Overflow: byte 2047 is discarded.
        build_frame(1, 2038, 1'b0);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);

        // Reset in the middle of a frame.
        mon_en = 1'b0;
        build_frame(1, 4, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1;
            rx_data = (i == 8) ? 4'hD : 4'h5;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            rx_data = 4'hF;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("midreset");
        rx_dv = 1'b0;
        rst_n = 1'b1;
        rdy_prev = 1'b0;
        mon_en = 1'b1;
        build_frame(0, 20, 1'b1);
        expect_frame(1'b1, 1'b0, 1'b0);
        send_frame(15, -1, 1'b0, -1);
        wait_ready("after_reset");
        ack();

        repeat (5) @(posedge clk);
        chk("writes_drained", 32'(wq.size()), 0);
        chk("events_drained", 32'(eq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
